// File: rtl/mips16_pkg.sv
// Shared MIPS16 widths, data-bridge FSM states and the error read value.
package mips16_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } dmem_state_t;
endpackage

// File: rtl/dmem_bus_bridge_if.sv
// External req/ack data bus between the MEM-stage bridge (master) and the memory slave.
interface dmem_bus_bridge_if;
  import mips16_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Turns MEM-stage loads/stores into req/ack bus transactions, stalling the pipeline
// until ack or timeout; each access costs IDLE->REQ->DONE, at least 3 cycles.
module dmem_bus_bridge
  import mips16_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_access_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_write_en,
  input  logic              mem_read_en,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_stall_n,
  dmem_bus_bridge_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dmem_state_t       r_state;
  dmem_state_t       w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_req_in;
  logic              w_timeout;
  logic              w_bus_req;
  logic              w_unused_addr_hi;

  assign w_req_in  = mem_write_en | mem_read_en;
  assign w_timeout = (r_cnt == CNT_LAST);
  // Address bits above the bus width are deliberately dropped (address wraps).
  assign w_unused_addr_hi = ^mem_access_addr[DATA_W-1:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    mem_stall_n = 1'b1;
    w_bus_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_in) begin
          mem_stall_n = 1'b0;
          w_next      = REQ;
        end
      end
      REQ: begin
        w_bus_req   = 1'b1;
        mem_stall_n = 1'b0;
        if (bus.bus_ack || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      if (w_req_in) begin
        r_addr  <= mem_access_addr[ADDR_W-1:0];
        r_wdata <= mem_write_data;
        r_we    <= mem_write_en;
      end
    end else if (r_state == REQ) begin
      r_cnt <= r_cnt + 1'b1;
      // Ack beats a coincident timeout, leaving the error flag untouched.
      if (bus.bus_ack) begin
        if (!r_we) r_rdata <= bus.bus_rdata;
      end else if (w_timeout) begin
        if (!r_we) r_rdata <= ERR_DATA;
        r_err <= 1'b1;
      end
    end
  end

  assign mem_read_data = r_rdata;
  assign bus.bus_req   = w_bus_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_err   = r_err;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: loads, stores, timeouts, stray acks, mid-access reset.
module tb_dmem_bus_bridge;
  import mips16_pkg::*;

  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_stall_n;

  dmem_bus_bridge_if bus ();

  dmem_bus_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_read_data   (mem_read_data),
    .mem_stall_n     (mem_stall_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_rdata;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the next IDLE cycle.
  // ack_dly = number of REQ cycles without ack before the ack cycle; -1 = never ack.
  task automatic run_access(input string tag, input logic we, input logic re,
                            input logic [15:0] addr, input logic [15:0] wd,
                            input int ack_dly, input logic [15:0] rd);
    exp_t        e;
    int          stalls = 0;
    int          reqs   = 0;
    bit          done   = 0;
    bit          acked;
    logic        s_we   = 1'b0;
    logic [7:0]  s_addr = 8'h00;
    logic [15:0] s_wd   = 16'h0000;
    acked = (ack_dly >= 0) && (ack_dly < TIMEOUT);
    if (!we) m_rdata = acked ? rd : ERR_DATA;
    if (!acked) m_err = 1'b1;
    e.we     = we;
    e.addr   = addr[7:0];
    e.wdata  = wd;
    e.rdata  = m_rdata;
    e.err    = m_err;
    e.reqs   = acked ? ack_dly + 1 : TIMEOUT;
    e.stalls = 1 + e.reqs;
    sb_q.push_back(e);

    mem_write_en    = we;
    mem_read_en     = re;
    mem_access_addr = addr;
    mem_write_data  = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      bus.bus_ack = 1'b0;
      if (mem_stall_n) done = 1;
      else begin
        stalls++;
        if (bus.bus_req) begin
          reqs++;
          s_we   = bus.bus_we;
          s_addr = bus.bus_addr;
          s_wd   = bus.bus_wdata;
          if (reqs - 1 == ack_dly) begin
            bus.bus_ack   = 1'b1;
            bus.bus_rdata = rd;
          end
        end
      end
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    e = sb_q.pop_front();
    chk({tag, " stall_cycles"}, stalls,            e.stalls);
    chk({tag, " req_cycles"},   reqs,              e.reqs);
    chk({tag, " bus_we"},       32'(s_we),         32'(e.we));
    chk({tag, " bus_addr"},     32'(s_addr),       32'(e.addr));
    chk({tag, " bus_wdata"},    32'(s_wd),         32'(e.wdata));
    chk({tag, " read_data"},    32'(mem_read_data), 32'(e.rdata));
    chk({tag, " bus_err"},      32'(bus.bus_err),  32'(e.err));
    chk({tag, " done_req_low"}, 32'(bus.bus_req),  32'd0);
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2;
    rst             = 1'b1;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    bus.bus_ack     = 1'b0;
    bus.bus_rdata   = '0;
    m_rdata         = 16'h0000;
    m_err           = 1'b0;
    #1;
    chk("rst read_data", 32'(mem_read_data), 32'h0);
    chk("rst bus_req",   32'(bus.bus_req),   32'h0);
    chk("rst bus_we",    32'(bus.bus_we),    32'h0);
    chk("rst bus_addr",  32'(bus.bus_addr),  32'h0);
    chk("rst bus_wdata", 32'(bus.bus_wdata), 32'h0);
    chk("rst bus_err",   32'(bus.bus_err),   32'h0);
    chk("rst stall_n",   32'(mem_stall_n),   32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_access("load_wait2",  1'b0, 1'b1, 16'h0012, 16'h0000, 2,  16'h1234);
    run_access("store_0wait", 1'b1, 1'b0, 16'h0105, 16'hBEEF, 0,  16'h7777);
    run_access("ack_at_tmo",  1'b0, 1'b1, 16'h0033, 16'h0000, TIMEOUT - 1, 16'hA5A5);

    // Stray ack while idle must be ignored
    @(negedge clk);
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 16'h5555;
    @(negedge clk);
    chk("stray stall_n",   32'(mem_stall_n),   32'h1);
    chk("stray bus_req",   32'(bus.bus_req),   32'h0);
    chk("stray read_data", 32'(mem_read_data), 32'(m_rdata));
    bus.bus_ack = 1'b0;
    @(posedge clk);
    #1;

    run_access("both_en", 1'b1, 1'b1, 16'h0044, 16'hCAFE, 1, 16'h9999);

    t0 = cycle;
    run_access("b2b_ld1", 1'b0, 1'b1, 16'h0050, 16'h0000, 0, 16'h1111);
    t1 = cycle;
    run_access("b2b_ld2", 1'b0, 1'b1, 16'h0051, 16'h0000, 0, 16'h2222);
    t2 = cycle;
    chk("b2b ld1 cycles", t1 - t0, 3);
    chk("b2b ld2 cycles", t2 - t1, 3);

    run_access("timeout_rd", 1'b0, 1'b1, 16'h0077, 16'h0000, -1, 16'h0000);
    run_access("after_tmo",  1'b0, 1'b1, 16'h0078, 16'h0000, 1,  16'h3C3C);

    // Reset while a load sits in REQ
    mem_read_en     = 1'b1;
    mem_access_addr = 16'h0022;
    @(negedge clk);
    @(negedge clk);
    chk("rstreq in_req", 32'(bus.bus_req), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstreq bus_req",   32'(bus.bus_req),   32'h0);
    chk("rstreq bus_err",   32'(bus.bus_err),   32'h0);
    chk("rstreq read_data", 32'(mem_read_data), 32'h0);
    chk("rstreq bus_addr",  32'(bus.bus_addr),  32'h0);
    mem_read_en = 1'b0;
    #1;
    chk("rstreq idle", 32'(mem_stall_n), 32'h1);
    m_rdata = 16'h0000;
    m_err   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_access("post_rst_ld", 1'b0, 1'b1, 16'h0122, 16'h0000, 1, 16'h4321);

    chk("scoreboard empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
